key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Upstream front-end for clock_top's pushbutton inputs (KEY[3:0], active-low, asynchronous to clk).
//  - Synchronises each key into the clk domain and debounces it.
//  - Produces a clean pressed level, plus one-cycle press and release pulses.
//  - clock_top consumes the pulses for mode-advance and increment, instead of raw KEY levels.
// PARAMETERS
//  NUM_KEYS         4           number of independent keys
//  DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles needed to accept a level change (20 ms @ 50 MHz); legal range >= 1
//  REPEAT_DELAY     25_000_000  auto-repeat: cycles from first press_pulse to first repeat (KEY_AUTOREPEAT_EN only)
//  REPEAT_PERIOD    5_000_000   auto-repeat: cycles between subsequent repeats (KEY_AUTOREPEAT_EN only)
//  REPEAT_MASK      4'b0001     auto-repeat: per-key enable, bit i = key i (KEY_AUTOREPEAT_EN only)
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         reset: asynchronous assert, active-low
//  key_n          in   NUM_KEYS  raw pushbuttons; 0 = pressed
//  pressed        out  NUM_KEYS  debounced level; 1 = held
//  press_pulse    out  NUM_KEYS  one-cycle strobe on accepted press (and on each auto-repeat)
//  release_pulse  out  NUM_KEYS  one-cycle strobe on accepted release
// BEHAVIOUR
//  Reset
//   - Sync flops reset to 1 (released); counters reset to 0; state RELEASED.
//   - pressed, press_pulse and release_pulse reset to 0.
//   - Reset mid-debounce or mid-repeat discards all progress. No pulse is emitted on reset entry or exit.
//  Synchroniser
//   - 2-flop per key; sync_i = key_n[i] delayed 2 edges.
//  Per-key FSM
//   - RELEASED: sync_i==0 -> PRESS_WAIT, cnt=1.
//   - PRESS_WAIT: sync_i==1 -> RELEASED, cnt=0 (bounce rejected).
//     Otherwise, if cnt==DEBOUNCE_CYCLES -> HELD, pressed=1, press_pulse=1 for one cycle. Else cnt++.
//   - HELD: sync_i==1 -> RELEASE_WAIT, cnt=1.
//   - RELEASE_WAIT: sync_i==0 -> HELD, cnt=0 (no pulse).
//     Otherwise, if cnt==DEBOUNCE_CYCLES -> RELEASED, pressed=0, release_pulse=1 for one cycle. Else cnt++.
//  Latency
//   - Clean edge sampled at edge N -> pulse and level change visible after edge N+2+DEBOUNCE_CYCLES.
//   - DEBOUNCE_CYCLES==1 gives minimum latency of 3.
//  Counter
//   - Width $clog2(DEBOUNCE_CYCLES+1); never wraps because the FSM exits at terminal count.
//  Independence and pulses
//   - Keys are fully independent; simultaneous presses on several keys produce simultaneous pulses.
//   - press_pulse and release_pulse are never high together on one key.
//  Held at reset release
//   - A key held at reset release is treated as a fresh press after the debounce time.
// CONFIGURATION
//  Macro KEY_AUTOREPEAT_EN
//   - Defined: for key i with REPEAT_MASK[i]=1 in HELD, a per-key repeat counter runs.
//     press_pulse re-fires REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
//   - Leaving HELD clears the counter. In RELEASE_WAIT, repeat is suspended; a return to HELD restarts from REPEAT_DELAY.
//  Macro undefined
//   - No repeat logic is generated; REPEAT_* parameters are ignored.
//   - Exactly one press_pulse per accepted press.
// STRUCTURE
//  Package key_cond_pkg
//   - key_state_e enum {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT}.
//   - Default timing constants DEF_DEBOUNCE_CYCLES, DEF_REPEAT_DELAY and DEF_REPEAT_PERIOD.
//  Sub-module key_debounce_1
//   - One key: synchroniser + FSM + counter (+ repeat counter).
//   - Instantiated NUM_KEYS times in a generate loop.
//   - The top level only assembles the bit vectors.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset held, key_n=4'b1111 -> all outputs 0.
//    Release reset with key_n=4'b1111 -> outputs stay 0 for 50 cycles.
//  2 key_n[0] 1->0 cleanly at edge N -> press_pulse[0]=1 after edge N+6 only; pressed[0]=1 from then.
//    Release -> release_pulse[0] one cycle, 6 edges later.
//  3 key_n[1] toggles 0/1 every 2 cycles for 20 cycles, then settles high -> no pulses, pressed[1]=0 throughout.
//  4 key_n[1] and key_n[3] pressed on the same edge -> press_pulse=4'b1010 in one cycle.
//  5 rst_n pulsed low while key_n[0] is in PRESS_WAIT (cnt=2) -> no pulse.
//    Key still held -> press_pulse[0] 6 edges after reset release.
//  6 KEY_AUTOREPEAT_EN defined; key_n[0] held 30 cycles after accept -> press_pulse[0] at +0,+10,+13,+16,...
//    key_n[1] held -> single pulse. Macro undefined -> single pulse on key 0.

Source files
------------

// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Purpose : Shared types and default timing constants for the pushbutton
//           conditioner (key_conditioner / key_debounce_1).
// Contents: key_state_e     per-key debounce state
//           DEF_*           default timing constants (50 MHz system clock)
//           max_int()       elaboration helper for counter sizing
// -----------------------------------------------------------------------------
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_1.sv
// -----------------------------------------------------------------------------
// key_debounce_1
// Purpose : Conditions one active-low pushbutton: 2-flop synchroniser, debounce
//           FSM with a stability counter, and (when KEY_AUTOREPEAT_EN is
//           defined) an auto-repeat counter that re-fires press pulses while
//           the key stays held.
// Ports   : clk              system clock
//           rst_n            asynchronous active-low reset
//           i_key_n          raw key, 0 = pressed, asynchronous to clk
//           o_pressed        debounced level, 1 = held
//           o_press_pulse    one-cycle strobe on accepted press / repeat
//           o_release_pulse  one-cycle strobe on accepted release
// Config  : KEY_AUTOREPEAT_EN adds REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN.
// -----------------------------------------------------------------------------
module key_debounce_1
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef KEY_AUTOREPEAT_EN
    // Repeat counter counts down to zero; the pulse fires on the zero cycle,
    // so it is loaded with (interval - 1).
    localparam int            RW       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] C_DELAY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] C_PERIOD = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rcnt;
`endif

    logic          r_sync1;
    logic          r_sync2;
    key_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_state         <= RELEASED;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_rcnt          <= '0;
`endif
        end else begin
            r_sync1         <= i_key_n;
            r_sync2         <= r_sync1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (!r_sync2) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= C_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (r_sync2) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_TERM) begin
                        r_state       <= HELD;
                        r_cnt         <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        r_rcnt        <= C_DELAY;
`endif
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                HELD: begin
                    if (r_sync2) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= C_ONE;
`ifdef KEY_AUTOREPEAT_EN
                        r_rcnt  <= '0;
                    end else if (REPEAT_EN) begin
                        if (r_rcnt == '0) begin
                            r_press_pulse <= 1'b1;
                            r_rcnt        <= C_PERIOD;
                        end else begin
                            r_rcnt <= r_rcnt - 1'b1;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (!r_sync2) begin
                        // Bounce on release: back to HELD silently, repeat
                        // timing restarts from the initial delay.
                        r_state <= HELD;
                        r_cnt   <= '0;
`ifdef KEY_AUTOREPEAT_EN
                        r_rcnt  <= C_DELAY;
`endif
                    end else if (r_cnt == C_TERM) begin
                        r_state         <= RELEASED;
                        r_cnt           <= '0;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Purpose : Front-end for active-low pushbuttons. Each key is synchronised,
//           debounced and turned into a clean level plus press/release pulses
//           by an independent key_debounce_1 instance.
// Ports   : clk            system clock
//           rst_n          asynchronous active-low reset
//           key_n          raw pushbuttons, 0 = pressed
//           pressed        debounced levels, 1 = held
//           press_pulse    one-cycle strobes on accepted press (and repeats)
//           release_pulse  one-cycle strobes on accepted release
// Config  : KEY_AUTOREPEAT_EN enables auto-repeat and the REPEAT_DELAY,
//           REPEAT_PERIOD and REPEAT_MASK parameters.
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int                  REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int                  REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = 1
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce_1 #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[gi])
`endif
            ) u_key (
                .clk             (clk),
                .rst_n           (rst_n),
                .i_key_n         (key_n[gi]),
                .o_pressed       (pressed[gi]),
                .o_press_pulse   (press_pulse[gi]),
                .o_release_pulse (release_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int         NK    = 4;
    localparam int         DB    = 4;
    localparam int         RD    = 10;
    localparam int         RP    = 3;
    localparam logic [3:0] RMASK = 4'b0001;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (RMASK)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a key's accepted level flips once the level seen
    // through the two-stage delay has differed from it for DB+1 consecutive
    // samples. Repeats counted in edges since press acceptance (or since a
    // return from a release bounce).
    bit         m_s1  [NK];
    bit         m_s2  [NK];
    bit         m_lvl [NK];
    int         m_run [NK];
    int         m_t   [NK];
    logic [3:0] e_pr, e_pp, e_rp;

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
            m_run[i] = 0;   m_t[i] = 0;
        end
        e_pr = '0; e_pp = '0; e_rp = '0;
    endtask

    task automatic model_edge();
        bit samp;
        for (int i = 0; i < NK; i++) begin
            samp    = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = key_n[i];
            e_pp[i] = 1'b0;
            e_rp[i] = 1'b0;
            if ((samp == 1'b0) != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB + 1) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    m_t[i]   = 0;
                    if (m_lvl[i]) e_pp[i] = 1'b1;
                    else          e_rp[i] = 1'b1;
                end
            end else if (m_run[i] > 0) begin
                m_run[i] = 0;
                m_t[i]   = 0;
            end else if (m_lvl[i] && AR && RMASK[i]) begin
                m_t[i]++;
                if (m_t[i] >= RD && ((m_t[i] - RD) % RP) == 0) e_pp[i] = 1'b1;
            end
            e_pr[i] = m_lvl[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) model_edge();
        chk("pressed",       32'(pressed),       32'(e_pr));
        chk("press_pulse",   32'(press_pulse),   32'(e_pp));
        chk("release_pulse", 32'(release_pulse), 32'(e_rp));
        chk("pulse_overlap", 32'(press_pulse & release_pulse), 32'd0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs", 32'({pressed, press_pulse, release_pulse}), 32'd0);
    endtask

    initial begin
        int cnt0, cnt1, w;
        int hold [NK];

        // 1: reset held, then 50 idle cycles
        model_reset();
        key_n = 4'hF;
        assert_reset();
        repeat (3) step();
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            chk("t1_idle", 32'({pressed, press_pulse, release_pulse}), 32'd0);
        end

        // 2: clean press then release on key 0
        key_n[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_press_pulse", 32'(press_pulse[0]), 32'(k == 6));
            chk("t2_pressed",     32'(pressed[0]),     32'(k >= 6));
        end
        repeat (3) step();
        key_n[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_release_pulse", 32'(release_pulse[0]), 32'(k == 6));
            chk("t2_released",      32'(pressed[0]),       32'(k < 6));
        end

        // 3: key 1 bouncing every 2 cycles, then settles high
        for (int c = 0; c < 30; c++) begin
            key_n[1] = (c < 20) ? (((c / 2) % 2) != 0) : 1'b1;
            step();
            chk("t3_bounce", 32'({pressed[1], press_pulse[1], release_pulse[1]}), 32'd0);
        end

        // 4: keys 1 and 3 pressed on the same edge
        key_n = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t4_press_pulse", 32'(press_pulse), (k == 6) ? 32'hA : 32'h0);
        end
        key_n = 4'hF;
        repeat (10) step();

        // 5: reset during PRESS_WAIT, key still held afterwards
        key_n[0] = 1'b0;
        repeat (4) step();
        assert_reset();
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t5_press_pulse", 32'(press_pulse[0]), 32'(k == 6));
        end
        key_n = 4'hF;
        repeat (12) step();

        // 6: long hold on keys 0 and 1; repeats only on masked key 0
        key_n[0] = 1'b0;
        key_n[1] = 1'b0;
        w = 0;
        do begin
            step();
            w++;
        end while (!press_pulse[0] && w < 20);
        chk("t6_accept", 32'(press_pulse[0]), 32'd1);
        cnt0 = 1;
        cnt1 = int'(press_pulse[1]);
        for (int k = 1; k <= 30; k++) begin
            step();
            cnt0 += int'(press_pulse[0]);
            cnt1 += int'(press_pulse[1]);
        end
        chk("t6_key0_pulses", 32'(cnt0), AR ? 32'd8 : 32'd1);
        chk("t6_key1_pulses", 32'(cnt1), 32'd1);
        key_n = 4'hF;
        repeat (12) step();

        // Random phase: mix of bounces, short and long holds, one mid-run reset
        for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 8);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    hold[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                           : $urandom_range(1, 8);
                end else begin
                    hold[i]--;
                end
            end
            if (c == 300) begin
                assert_reset();
                repeat (2) step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
